// File: rtl/btn_debounce4.sv
// Four-channel push-button conditioner: 2-flop synchroniser, debounce FSM and
// one-cycle press / release / long-press pulses per channel.
module btn_debounce4 #(
  parameter int unsigned DEBOUNCE_CYCLES = 200000,
  parameter int unsigned LONG_CYCLES     = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_in,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_long
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW  = $clog2(LONG_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  state_t         state [NCH];
  logic [CW-1:0]  cnt   [NCH];
  logic [HW-1:0]  hold  [NCH];

  // Per-channel debounce FSM; hold keeps running through release bounce so a
  // glitch during a long press does not restart the long timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        hold[i]  <= '0;
      end
    end else begin
      sync1       <= btn_in;
      sync2       <= sync1;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      for (int i = 0; i < NCH; i++) begin
        if (state[i] == PRESSED || state[i] == RELEASE_PEND) begin
          if (hold[i] != HW'(LONG_CYCLES)) begin
            hold[i] <= hold[i] + HW'(1);
          end
          if (hold[i] == HW'(LONG_CYCLES - 1)) begin
            btn_long[i] <= 1'b1;
          end
        end
        case (state[i])
          IDLE: begin
            if (sync2[i]) begin
              state[i] <= PRESS_PEND;
              cnt[i]   <= CW'(1);
            end
          end
          PRESS_PEND: begin
            if (!sync2[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
              state[i]     <= PRESSED;
              cnt[i]       <= '0;
              hold[i]      <= '0;
              btn_level[i] <= 1'b1;
              btn_press[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          PRESSED: begin
            if (!sync2[i]) begin
              state[i] <= RELEASE_PEND;
              cnt[i]   <= CW'(1);
            end
          end
          RELEASE_PEND: begin
            if (sync2[i]) begin
              state[i] <= PRESSED;
              cnt[i]   <= '0;
            end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
              state[i]       <= IDLE;
              cnt[i]         <= '0;
              hold[i]        <= '0;
              btn_level[i]   <= 1'b0;
              btn_release[i] <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce4.sv
// Self-checking bench for btn_debounce4: run-length reference model compared
// every cycle, directed scenarios with literal timing checks, then random stimulus.
module tb_btn_debounce4;

  localparam int unsigned D = 8;
  localparam int unsigned L = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_in = 4'h0;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;

  btn_debounce4 #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_long(btn_long)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // reference model state
  logic [3:0] m_sync1 = 0, m_sync2 = 0, m_level = 0, m_press = 0, m_rel = 0, m_long = 0;
  int m_run [4];
  int m_age [4];

  // observed events
  int press_cnt [4];
  int rel_cnt [4];
  int long_cnt [4];
  int press_cyc [4];
  int rel_cyc [4];
  int long_cyc [4];
  logic [3:0] last_press_vec = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // A change is accepted after D consecutive synchronised samples differing from
  // the current level; the long pulse fires when L edges have elapsed since accept.
  task automatic model_step();
    logic [3:0] s;
    if (!rst_n) begin
      m_sync1 = 0; m_sync2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_age[i] = 0; end
    end else begin
      s = m_sync2;
      m_sync2 = m_sync1;
      m_sync1 = btn_in;
      m_press = 0; m_rel = 0; m_long = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_level[i] && m_age[i] < int'(L)) begin
          m_age[i]++;
          if (m_age[i] == int'(L)) m_long[i] = 1'b1;
        end
        if (s[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(D)) begin
            m_level[i] = ~m_level[i];
            if (m_level[i]) m_press[i] = 1'b1;
            else            m_rel[i]   = 1'b1;
            m_run[i] = 0;
            m_age[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_age[i] = 0;
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
      press_cyc[i] = 0; rel_cyc[i] = 0; long_cyc[i] = 0;
    end
  end

  // Compare process: sample #1 after every rising edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      chk("level",   int'(btn_level),   int'(m_level));
      chk("press",   int'(btn_press),   int'(m_press));
      chk("release", int'(btn_release), int'(m_rel));
      chk("long",    int'(btn_long),    int'(m_long));
      for (int i = 0; i < 4; i++) begin
        if (btn_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
        if (btn_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
        if (btn_long[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
      end
      if (btn_press != 4'h0) last_press_vec = btn_press;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int c0, c1, p, r, lg, p3, r3;
  int tmr [4];

  initial begin
    // 1. reset with all buttons held
    btn_in = 4'hF;
    cycles(3);
    chk("rst_level_zero", int'(btn_level), 0);
    chk("rst_press_zero", int'(btn_press), 0);
    rst_n = 1'b1;
    c0 = cyc;
    cycles(12);
    chk("rst_accept_edge", press_cyc[0] - c0, 10);
    chk("rst_press_vec", int'(last_press_vec), 15);
    chk("rst_level_all", int'(btn_level), 15);
    btn_in = 4'h0;
    cycles(15);

    // 2. bounce reject on channel 0
    p = press_cnt[0]; r = rel_cnt[0];
    btn_in[0] = 1'b1; cycles(5);
    btn_in[0] = 1'b0; cycles(3);
    btn_in[0] = 1'b1; cycles(6);
    btn_in[0] = 1'b0; cycles(15);
    chk("bounce_no_press", press_cnt[0] - p, 0);
    chk("bounce_no_release", rel_cnt[0] - r, 0);

    // 3. clean press/release on channel 1
    lg = long_cnt[1];
    c0 = cyc; btn_in[1] = 1'b1; cycles(20);
    c1 = cyc; btn_in[1] = 1'b0; cycles(15);
    chk("clean_press_edge", press_cyc[1] - c0, 10);
    chk("clean_release_edge", rel_cyc[1] - c1, 10);
    chk("clean_no_long", long_cnt[1] - lg, 0);

    // 4. long press with a short low glitch on channel 2
    p = press_cnt[2]; r = rel_cnt[2]; lg = long_cnt[2];
    c0 = cyc;
    btn_in[2] = 1'b1; cycles(30);
    btn_in[2] = 1'b0; cycles(3);
    btn_in[2] = 1'b1; cycles(47);
    chk("long_one_press", press_cnt[2] - p, 1);
    chk("long_one_long", long_cnt[2] - lg, 1);
    chk("long_no_release", rel_cnt[2] - r, 0);
    chk("long_delay", long_cyc[2] - press_cyc[2], 40);
    chk("long_press_edge", press_cyc[2] - c0, 10);
    c1 = cyc; btn_in[2] = 1'b0; cycles(15);
    chk("long_final_release", rel_cnt[2] - r, 1);
    chk("long_release_edge", rel_cyc[2] - c1, 10);

    // 5. simultaneous press, then reset mid-press
    btn_in[3] = 1'b1; btn_in[0] = 1'b1;
    cycles(12);
    chk("simul_press_vec", int'(last_press_vec), 9);
    chk("simul_same_cycle", press_cyc[3] - press_cyc[0], 0);
    r = rel_cnt[0]; r3 = rel_cnt[3];
    rst_n = 1'b0;
    #1;
    chk("async_level_drop", int'(btn_level), 0);
    btn_in = 4'h0;
    cycles(3);
    chk("reset_no_release", (rel_cnt[0] - r) + (rel_cnt[3] - r3), 0);
    rst_n = 1'b1;
    cycles(5);

    // 6. boundary: 8 samples accepted, 7 rejected
    p = press_cnt[1]; r = rel_cnt[1];
    btn_in[1] = 1'b1; cycles(8);
    btn_in[1] = 1'b0; cycles(15);
    chk("pulse8_press", press_cnt[1] - p, 1);
    chk("pulse8_release", rel_cnt[1] - r, 1);
    p = press_cnt[1];
    btn_in[1] = 1'b1; cycles(7);
    btn_in[1] = 1'b0; cycles(15);
    chk("pulse7_reject", press_cnt[1] - p, 0);

    // random stimulus with occasional long holds and resets
    p3 = press_cnt[3];
    for (int i = 0; i < 4; i++) tmr[i] = $urandom_range(1, 12);
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        tmr[i]--;
        if (tmr[i] <= 0) begin
          btn_in[i] = ~btn_in[i];
          if (btn_in[i] && $urandom_range(0, 4) == 0) tmr[i] = $urandom_range(45, 60);
          else tmr[i] = $urandom_range(1, 14);
        end
      end
      if ($urandom_range(0, 699) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    rst_n = 1'b1;
    btn_in = 4'h0;
    cycles(20);
    if (press_cnt[3] == p3) begin
      n_checks++; n_fail++;
      $display("FAIL random_activity: got 0 presses expected some");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
